// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus types and arbiter state encoding
package bus_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0] byte_mask_t;
  typedef enum logic [1:0] {IDLE, LOCK_D, LOCK_I} arb_state_t;
endpackage

// File: rtl/bus_arb_starve_ctr.sv
// bus_arb_starve_ctr: saturating count of D wins while I waits
module bus_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [3:0] cnt_q, cnt_d;
  // clear wins over increment; hold once the limit is reached
  always_comb cnt_d = clr ? 4'd0 : (inc && !at_limit) ? cnt_q + 4'd1 : cnt_q;
  assign at_limit = cnt_q == 4'(MAX_WAIT);
  // counter register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: D-over-I fixed priority bus arbiter with grant lock and starvation guard
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  word_t      d_address,
  input  logic       d_read,
  input  logic       d_write,
  input  word_t      d_data_wr,
  input  byte_mask_t d_mask,
  output logic       d_stall,
  output word_t      d_data_rd,
  output word_t      d_data_rd_2,
  input  word_t      i_address,
  input  logic       i_read,
  input  logic       i_write,
  input  word_t      i_data_wr,
  input  byte_mask_t i_mask,
  output logic       i_stall,
  output word_t      i_data_rd,
  output word_t      i_data_rd_2,
  output word_t      s_address,
  output logic       s_read,
  output logic       s_write,
  output word_t      s_data_wr,
  output byte_mask_t s_mask,
  input  logic       s_stall,
  input  word_t      s_data_rd,
  input  word_t      s_data_rd_2
);
  arb_state_t state_q, state_d;
  logic req_d, req_i, win_i, own_d, own_i, own_req, done, at_limit;
  assign req_d = d_read | d_write;
  assign req_i = i_read | i_write;
  // ownership: locked owner, else same-cycle grant; nobody owns during reset
  always_comb begin
    win_i   = req_i & (~req_d | at_limit);
    own_i   = rst & (state_q == LOCK_I | (state_q == IDLE & win_i));
    own_d   = rst & (state_q == LOCK_D | (state_q == IDLE & req_d & ~win_i));
    own_req = (own_d & req_d) | (own_i & req_i);
    done    = own_req & ~s_stall;
    state_d = (own_req & s_stall) ? (own_d ? LOCK_D : LOCK_I) : IDLE;
  end
  // forward the owner to the slave; idle bus is all zeros
  always_comb begin
    s_address = own_d ? d_address : own_i ? i_address : '0;
    s_read    = own_d ? d_read    : own_i ? i_read    : 1'b0;
    s_write   = own_d ? d_write   : own_i ? i_write   : 1'b0;
    s_data_wr = own_d ? d_data_wr : own_i ? i_data_wr : '0;
    s_mask    = own_d ? d_mask    : own_i ? i_mask    : '0;
    d_stall   = req_d & (own_d ? s_stall : 1'b1);
    i_stall   = req_i & (own_i ? s_stall : 1'b1);
  end
  assign d_data_rd   = s_data_rd;
  assign d_data_rd_2 = s_data_rd_2;
  assign i_data_rd   = s_data_rd;
  assign i_data_rd_2 = s_data_rd_2;
  bus_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (own_d & done & req_i),
    .clr      ((own_i & done) | ~req_i),
    .at_limit (at_limit)
  );
  // state register, forced to IDLE asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a cycle-level reference model of the arbiter
module tb_bus_arbiter;
  localparam int MW = 4;
  localparam logic [31:0] DA = 32'h0000_0010, IA = 32'h0000_0200;
  logic clk = 0, rst = 0;
  logic [31:0] d_address = 0, d_data_wr = 0, i_address = 0, i_data_wr = 0;
  logic [31:0] s_data_rd = 0, s_data_rd_2 = 0;
  logic [3:0] d_mask = 0, i_mask = 0;
  logic d_read = 0, d_write = 0, i_read = 0, i_write = 0, s_stall = 0;
  logic d_stall, i_stall, s_read, s_write;
  logic [31:0] d_data_rd, d_data_rd_2, i_data_rd, i_data_rd_2, s_address, s_data_wr;
  logic [3:0] s_mask;
  int n_cmp = 0, n_bad = 0;
  int m_lock = 0, m_cnt = 0;

  bus_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_data_wr(d_data_wr),
    .d_mask(d_mask), .d_stall(d_stall), .d_data_rd(d_data_rd), .d_data_rd_2(d_data_rd_2),
    .i_address(i_address), .i_read(i_read), .i_write(i_write), .i_data_wr(i_data_wr),
    .i_mask(i_mask), .i_stall(i_stall), .i_data_rd(i_data_rd), .i_data_rd_2(i_data_rd_2),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_data_wr(s_data_wr),
    .s_mask(s_mask), .s_stall(s_stall), .s_data_rd(s_data_rd), .s_data_rd_2(s_data_rd_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: owner 0=none 1=D 2=I; m_lock is the locked owner, m_cnt the starvation count
  always @(negedge clk) begin
    int own;
    bit rd, ri, oreq;
    logic [31:0] ea, ew;
    logic [3:0] em;
    logic er, ewr;
    rd = d_read | d_write;
    ri = i_read | i_write;
    chk("d_data_rd", d_data_rd, s_data_rd);
    chk("i_data_rd_2", i_data_rd_2, s_data_rd_2);
    if (!rst) begin
      m_lock = 0;
      m_cnt = 0;
      chk("rst s_read", {31'd0, s_read}, 0);
      chk("rst s_write", {31'd0, s_write}, 0);
      chk("rst s_address", s_address, 0);
      chk("rst d_stall", {31'd0, d_stall}, {31'd0, rd});
      chk("rst i_stall", {31'd0, i_stall}, {31'd0, ri});
    end else begin
      if (m_lock != 0) own = m_lock;
      else if (ri && (!rd || m_cnt == MW)) own = 2;
      else if (rd) own = 1;
      else own = 0;
      ea = 0; ew = 0; em = 0; er = 0; ewr = 0;
      if (own == 1) begin ea = d_address; ew = d_data_wr; em = d_mask; er = d_read; ewr = d_write; end
      if (own == 2) begin ea = i_address; ew = i_data_wr; em = i_mask; er = i_read; ewr = i_write; end
      oreq = (own == 1 && rd) || (own == 2 && ri);
      chk("s_address", s_address, ea);
      chk("s_data_wr", s_data_wr, ew);
      chk("s_mask", {28'd0, s_mask}, {28'd0, em});
      chk("s_read", {31'd0, s_read}, {31'd0, er});
      chk("s_write", {31'd0, s_write}, {31'd0, ewr});
      chk("d_stall", {31'd0, d_stall}, {31'd0, rd && (own != 1 || s_stall)});
      chk("i_stall", {31'd0, i_stall}, {31'd0, ri && (own != 2 || s_stall)});
      chk("starve_cnt", {28'd0, dut.u_starve.cnt_q}, m_cnt);
      if (!ri) m_cnt = 0;
      else if (oreq && !s_stall && own == 2) m_cnt = 0;
      else if (oreq && !s_stall && own == 1 && m_cnt < MW) m_cnt++;
      m_lock = (oreq && s_stall) ? own : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_read = 0; d_write = 0; i_read = 0; i_write = 0; s_stall = 0;
  endtask

  initial begin
    d_address = DA; i_address = IA; d_data_wr = 32'h1111_1111; i_data_wr = 32'h2222_2222;
    d_mask = 4'hF; i_mask = 4'h5; s_data_rd = 32'h0000_1234; s_data_rd_2 = 32'h0000_5678;
    @(negedge clk);
    chk("reset s_read", {31'd0, s_read}, 0);
    step(); rst = 1;
    // 1: lone D read completes same cycle
    d_read = 1;
    @(negedge clk);
    chk("t1 s_read", {31'd0, s_read}, 1);
    chk("t1 s_address", s_address, 32'h10);
    chk("t1 d_stall", {31'd0, d_stall}, 0);
    chk("t1 d_data_rd", d_data_rd, 32'h1234);
    // 2: both request, I wins on the 5th cycle
    step(); i_read = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2 s_address", s_address, (k == 4) ? IA : DA);
      chk("t2 i_stall", {31'd0, i_stall}, (k == 4) ? 0 : 1);
      step();
    end
    // 3: I locked by stall, D waits then is granted
    idle_inputs(); step();
    i_read = 1; s_stall = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) d_read = 1;
      if (k == 3) s_stall = 0;
      @(negedge clk);
      chk("t3 s_address", s_address, IA);
      if (k >= 2) chk("t3 d_stall", {31'd0, d_stall}, 1);
      step();
    end
    i_read = 0;
    @(negedge clk);
    chk("t3 D granted", s_address, DA);
    chk("t3 d_stall after", {31'd0, d_stall}, 0);
    // 4: stalled D write aborted
    step(); idle_inputs(); step();
    d_write = 1; d_mask = 4'b0011; d_data_wr = 32'hDEAD_BEEF; s_stall = 1;
    @(negedge clk);
    chk("t4 s_mask", {28'd0, s_mask}, 32'h3);
    chk("t4 s_data_wr", s_data_wr, 32'hDEAD_BEEF);
    step(); step();
    d_write = 0;
    @(negedge clk);
    chk("t4 s_write drop", {31'd0, s_write}, 0);
    step(); s_stall = 0;
    @(negedge clk);
    chk("t4 idle addr", s_address, 0);
    // 5: reset during LOCK_D with I requesting
    step(); d_read = 1; s_stall = 1; i_read = 1;
    step();
    rst = 0; d_read = 0;
    @(negedge clk);
    chk("t5 s_read", {31'd0, s_read}, 0);
    chk("t5 i_stall", {31'd0, i_stall}, 1);
    step(); rst = 1; s_stall = 0;
    @(negedge clk);
    chk("t5 I granted", s_address, IA);
    chk("t5 i_stall after", {31'd0, i_stall}, 0);
    // 6: quiet bus
    step(); idle_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6 bus", {s_address[29:0], s_read, s_write}, 0);
      chk("t6 stalls", {30'd0, d_stall, i_stall}, 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one slave-side bus (address/read/write/data_wr/mask in; stall/data_rd/data_rd_2 out) between two CPU masters: data (D, MEM stage) and instruction fetch (I, IF stage).
- Sits between the CPU core and the address decoder/peripheral mux.
- Fixed priority D > I, with a starvation guard for I.
- Grants are locked for the full duration of multi-cycle (stalled) transactions.

Parameters:
- MAX_WAIT, 4, max consecutive completed D transactions while I is requesting before I is forced to win the next arbitration (1..15).

Ports:
- clk  in  1  system clock (the 50 MHz domain clock)
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- d_address  in  32  D master address
- d_read, d_write  in  1 each  D strobes
- d_data_wr  in  32  D write data
- d_mask  in  4  D byte mask
- d_stall  out  1  stall to D
- d_data_rd, d_data_rd_2  out  32 each  read data to D
- i_address, i_read, i_write, i_data_wr, i_mask, i_stall, i_data_rd, i_data_rd_2: same as the d_* ports, for I
- s_address  out  32  slave address
- s_read, s_write  out  1 each  slave strobes
- s_data_wr  out  32  slave write data
- s_mask  out  4  slave byte mask
- s_stall  in  1  slave busy
- s_data_rd, s_data_rd_2  in  32 each  slave read data

Behaviour:
- Request: req_x = x_read | x_write. A transaction completes in a cycle where the owner's req_x = 1 and s_stall = 0.
- State machine: IDLE, LOCK_D, LOCK_I. Reset: IDLE, starve_cnt = 0.
- IDLE, combinational same-cycle grant (zero added latency):
  - winner = I if req_i & (~req_d | starve_cnt == MAX_WAIT);
  - else D if req_d;
  - else none.
- LOCK_x: owner = x regardless of the other request.
- Forwarding: s_* = owner's signals. With no owner: s_read = s_write = 0, s_address/s_data_wr/s_mask = 0.
- Read data: s_data_rd/s_data_rd_2 are routed to both masters unconditionally. Only the owner's is meaningful.
- Stalls:
  - owner: x_stall = s_stall;
  - non-owner: x_stall = req_x (held until served);
  - no request: x_stall = 0.
- Transitions:
  - IDLE → LOCK_x when winner x and s_stall = 1.
  - IDLE stays IDLE when the winner completes in the same cycle.
  - LOCK_x → IDLE when x completes (s_stall = 0) or req_x drops (abort).
  - LOCK_x otherwise holds.
- Back-to-back: after a completion, next-cycle arbitration happens again in IDLE. A master holding req continuously with s_stall = 0 gets one access per cycle unless the starvation rule flips the grant.
- starve_cnt (4-bit, saturating at MAX_WAIT):
  - +1 when a D transaction completes while req_i = 1;
  - cleared when an I transaction completes or req_i = 0;
  - unchanged otherwise.
- Abort: if the owner deasserts req while s_stall = 1, the slave sees its strobes drop in that cycle. Return to IDLE. No completion is counted.
- Simultaneous request in LOCK release cycle: the release happens on the clock edge. Arbitration occurs in the following IDLE cycle. No grant switch mid-transaction.
- Reset mid-transaction (rst = 0):
  - state → IDLE, starve_cnt → 0 immediately (async);
  - while rst = 0: s_read = s_write = 0, s_address/s_data_wr/s_mask = 0;
  - while rst = 0: d_stall = req_d, i_stall = req_i.
- Masters must hold address/data/mask stable while their stall = 1. The arbiter does not register them.

Decomposition:
- Shared package: Word_t, ByteMask_t, and an ArbState_t enum {IDLE, LOCK_D, LOCK_I}.
- No master-ID typedef beyond the enum.
- One natural sub-module: bus_arb_starve_ctr (saturating counter with inc/clr/at_limit).
- The top level instantiates Bus_if.slave-style port groups as flattened signals.

Test Plan:
1. Only D reads 0x0000_0010, s_stall = 0 → s_read = 1 and s_address = 0x10 the same cycle; d_stall = 0; d_data_rd = s_data_rd; state stays IDLE.
2. D and I both request, s_stall = 0 → D owns; i_stall = 1; after 4 consecutive D completions (MAX_WAIT = 4) the 5th cycle grants I; i_stall = 0; starve_cnt returns to 0.
3. I read with s_stall = 1 for 3 cycles, then D requests in cycle 2 → state LOCK_I; s_address stays i_address; d_stall = 1 throughout; D granted in the cycle after s_stall falls.
4. D write (mask 4'b0011, data 0xDEAD_BEEF) stalled 2 cycles, then d_write drops → s_write falls that cycle; state → IDLE next edge; starve_cnt unchanged.
5. rst pulsed low during LOCK_D with I requesting → s_read = s_write = 0 immediately; i_stall = 1; after release, I granted in IDLE.
6. Neither master requesting → all s_* strobes and buses = 0; d_stall = i_stall = 0; state IDLE for 10 cycles.
